alu_hs: RTL and testbench
=========================

# alu_hs

Parametrised, handshaked successor to the team's registered 8-bit ALU. It keeps the existing 6-bit opcode encodings and adds status flags, shifts and an iterative shift-add multiplier. Valid/ready handshakes sit on both the operand side and the result side. It sits between the operand register file and the writeback stage, and can stall either side.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 4..32.
- CNTW, $clog2(WIDTH)+1, multiplier step-counter width.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; shift amount is b mod WIDTH.
- opcode  in  6  operation select.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block accepts operands this cycle.
- c  out  WIDTH  result (low half for Mul).
- c_hi  out  WIDTH  high half of Mul product; 0 for all other ops.
- flags  out  4  {n, z, cy, v}.
- illegal  out  1  opcode not in the table; qualified by out_valid.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes result.

## Operation
- Opcodes, unchanged from the current ALU:
  - Add 101001: a+b. Sub 000110: a-b. Zero 000011: 0.
  - And 011011, Or 011110, Xor 101100.
  - Add1 000001: a+1. Sub1 011111: a-1. Addsub1 010011: a+b-1.
  - Adt 111110: a. Bdt 110100: b. Nota 100000: ~a. Notb 101010: ~b.
- New opcodes:
  - Shl 001000: a<<s.
  - Shr 001001: logical a>>s.
  - Sar 001010: arithmetic a>>s.
  - Mul 110010: unsigned a*b as {c_hi,c}.
- Arithmetic wraps modulo 2^WIDTH.
- Flag rules:
  - z = (c==0).
  - n = c[WIDTH-1].
  - cy for Add/Sub/Add1/Sub1/Addsub1: 1 iff the exact unsigned result is outside [0, 2^WIDTH-1] (carry-out or borrow).
  - cy for shifts: last bit shifted out; 0 when s==0.
  - cy for Mul: (c_hi!=0).
  - cy for all other ops: 0.
  - v: two's-complement overflow for Add/Sub/Add1/Sub1/Addsub1; 0 otherwise.
- Illegal opcode:
  - c, c_hi and flags hold their previous values.
  - The result is still delivered with illegal=1.
- Mul is an iterative shift-add.
  - At acceptance, a and b are latched, the accumulator is cleared and the counter is loaded with WIDTH.
  - Each BUSY cycle: if multiplier LSB is 1, add the multiplicand; then shift the accumulator right; decrement the counter.
  - BUSY exits when the counter reaches 0.
- State machine:
  - IDLE: no result pending. in_ready=1. Accept with a single-cycle op → DONE. Accept with Mul → BUSY.
  - BUSY: in_ready=0. Counter reaches 0 → DONE with the result registered.
  - DONE: out_valid=1. in_ready=out_ready.
    - out_ready & in_valid with a single-cycle op: new result is registered, stay in DONE (back-to-back).
    - out_ready & in_valid with Mul → BUSY.
    - out_ready & !in_valid → IDLE.
    - !out_ready: hold c, c_hi, flags and illegal stable.
- Operand transfer occurs iff in_valid & in_ready. Operands need not stay stable after transfer.
- Result transfer occurs iff out_valid & out_ready.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, c=0, c_hi=0, flags=0, illegal=0, out_valid=0, counter=0.
  - in_ready is 0 during reset and 1 from the first cycle after release.
- Reset mid-operation (BUSY or DONE) discards the in-flight result. No out_valid is produced for it.
- Single-cycle op latency: operands accepted at edge k, out_valid=1 after edge k (visible in cycle k+1).
- Mul latency: accepted at edge k; out_valid rises after edge k+WIDTH+1; in_ready=0 for WIDTH+1 cycles.
- Throughput: one single-cycle op per clock while out_ready=1. Mul: one per WIDTH+2 cycles.
- in_ready is combinational from state and out_ready only; there is no path from in_valid to in_ready.
- out_valid, c, c_hi, flags and illegal are registered outputs.

## Test plan
- Reset then Add, WIDTH=8: a=0x7F, b=0x01, out_ready=1 → next cycle c=0x80, flags n=1 z=0 cy=0 v=1.
- Sub then Addsub1 back-to-back: Sub a=0x00 b=0x01 → c=0xFF, cy=1 n=1. Next Addsub1 a=0 b=0 → c=0xFF, cy=1. Expect two consecutive out_valid cycles.
- Mul: a=0xFF, b=0xFF → after 9 cycles {c_hi,c}=0xFE01, cy=1. in_ready=0 throughout BUSY.
- Backpressure: Xor a=0xF0 b=0xFF with out_ready=0 for 5 cycles → c=0x0F and out_valid stay stable, in_ready=0. out_ready=1 releases it in one transfer.
- Shifts and illegal: Sar a=0x90 b=0x0A (s=2) → c=0xE4, cy=0. Opcode 111111 → illegal=1, c still 0xE4.
- Reset in BUSY: rst_n=0 on the 4th Mul cycle → out_valid=0, c=0, c_hi=0. in_ready=1 the cycle after release. No stale result appears.

Source files
------------

// File: rtl/alu_hs.sv
// Handshaked ALU: single-cycle arithmetic/logic/shift ops plus an iterative
// shift-add multiplier, with valid/ready on both the operand and result sides.
module alu_hs #(
   parameter int WIDTH = 8,
   parameter int CNTW  = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [5:0]       opcode,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] c_hi,
   output logic [3:0]       flags,
   output logic             illegal,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int XW = WIDTH + 2;
   localparam logic [XW-1:0] ONE = XW'(1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

   typedef enum logic [5:0] {
      OP_ADD     = 6'b101001,
      OP_SUB     = 6'b000110,
      OP_ZERO    = 6'b000011,
      OP_AND     = 6'b011011,
      OP_OR      = 6'b011110,
      OP_XOR     = 6'b101100,
      OP_ADD1    = 6'b000001,
      OP_SUB1    = 6'b011111,
      OP_ADDSUB1 = 6'b010011,
      OP_ADT     = 6'b111110,
      OP_BDT     = 6'b110100,
      OP_NOTA    = 6'b100000,
      OP_NOTB    = 6'b101010,
      OP_SHL     = 6'b001000,
      OP_SHR     = 6'b001001,
      OP_SAR     = 6'b001010,
      OP_MUL     = 6'b110010
   } op_e;

   state_e             state;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] prod;
   logic [CNTW-1:0]    cnt;

   logic               accept;
   logic               is_mul;
   logic [SW-1:0]      shamt;
   logic [31:0]        b_ext;
   logic [WIDTH:0]     shl_t, shr_t, sar_t;
   logic [XW-1:0]      ua, ub, sa, sb, ux, sx;
   logic [WIDTH-1:0]   res;
   logic               res_cy, res_v, legal, arith;
   logic [WIDTH:0]     psum;

   // Refusing operands while reset is held keeps the upstream from losing a transfer.
   assign in_ready = rst_n & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
   assign accept   = in_valid & in_ready;
   assign is_mul   = (opcode == OP_MUL);

   assign b_ext = 32'(b);
   assign shamt = SW'(b_ext % 32'(WIDTH));
   // One guard bit on the side the bits leave from captures the last bit shifted out.
   assign shl_t = {1'b0, a} << shamt;
   assign shr_t = {a, 1'b0} >> shamt;
   assign sar_t = $signed({a, 1'b0}) >>> shamt;

   assign ua = XW'(a);
   assign ub = XW'(b);
   assign sa = {{2{a[WIDTH-1]}}, a};
   assign sb = {{2{b[WIDTH-1]}}, b};

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      res    = '0;
      res_cy = 1'b0;
      res_v  = 1'b0;
      legal  = 1'b1;
      arith  = 1'b0;
      ux     = '0;
      sx     = '0;
      case (opcode)
         OP_ADD:     begin ux = ua + ub;       sx = sa + sb;       arith = 1'b1; end
         OP_SUB:     begin ux = ua - ub;       sx = sa - sb;       arith = 1'b1; end
         OP_ADD1:    begin ux = ua + ONE;      sx = sa + ONE;      arith = 1'b1; end
         OP_SUB1:    begin ux = ua - ONE;      sx = sa - ONE;      arith = 1'b1; end
         OP_ADDSUB1: begin ux = ua + ub - ONE; sx = sa + sb - ONE; arith = 1'b1; end
         OP_ZERO:    res = '0;
         OP_AND:     res = a & b;
         OP_OR:      res = a | b;
         OP_XOR:     res = a ^ b;
         OP_ADT:     res = a;
         OP_BDT:     res = b;
         OP_NOTA:    res = ~a;
         OP_NOTB:    res = ~b;
         OP_SHL:     begin res = shl_t[WIDTH-1:0]; res_cy = shl_t[WIDTH]; end
         OP_SHR:     begin res = shr_t[WIDTH:1];   res_cy = shr_t[0];     end
         OP_SAR:     begin res = sar_t[WIDTH:1];   res_cy = sar_t[0];     end
         OP_MUL:     res = '0;
         default:    legal = 1'b0;
      endcase
      // Two extra bits hold the exact result: any set top bit means carry/borrow,
      // and the sign-extended sum overflows unless its top three bits agree.
      if (arith) begin
         res    = ux[WIDTH-1:0];
         res_cy = |ux[XW-1:WIDTH];
         res_v  = (|sx[XW-1:WIDTH-1]) & ~(&sx[XW-1:WIDTH-1]);
      end
   end

   assign psum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);

   // NOTE: state is updated with non-blocking assignments only, so every read in
   // this block sees the pre-edge value regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         c         <= '0;
         c_hi      <= '0;
         flags     <= '0;
         illegal   <= 1'b0;
         out_valid <= 1'b0;
         cnt       <= '0;
         mcand     <= '0;
         prod      <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  if (is_mul) begin
                     mcand     <= a;
                     prod      <= {{WIDTH{1'b0}}, b};
                     cnt       <= CNTW'(WIDTH);
                     out_valid <= 1'b0;
                     state     <= S_BUSY;
                  end else begin
                     // An illegal opcode still produces a result beat, but the
                     // datapath outputs keep whatever they last showed.
                     if (legal) begin
                        c     <= res;
                        c_hi  <= '0;
                        flags <= {res[WIDTH-1], (res == '0), res_cy, res_v};
                     end
                     illegal   <= ~legal;
                     out_valid <= 1'b1;
                     state     <= S_DONE;
                  end
               end else if (state == S_DONE && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            S_BUSY: begin
               if (cnt != '0) begin
                  prod <= {psum, prod[WIDTH-1:1]};
                  cnt  <= cnt - CNTW'(1);
               end else begin
                  c         <= prod[WIDTH-1:0];
                  c_hi      <= prod[2*WIDTH-1:WIDTH];
                  flags     <= {prod[WIDTH-1], (prod[WIDTH-1:0] == '0),
                                (prod[2*WIDTH-1:WIDTH] != '0), 1'b0};
                  illegal   <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_hs.sv
// Directed bench for alu_hs at WIDTH=8: reset, arithmetic flags, back-to-back,
// multiplier latency, backpressure, shifts, illegal opcode and reset while busy.
module tb_alu_hs;

   localparam logic [5:0] OP_ADD     = 6'b101001;
   localparam logic [5:0] OP_SUB     = 6'b000110;
   localparam logic [5:0] OP_ADDSUB1 = 6'b010011;
   localparam logic [5:0] OP_XOR     = 6'b101100;
   localparam logic [5:0] OP_ZERO    = 6'b000011;
   localparam logic [5:0] OP_SHL     = 6'b001000;
   localparam logic [5:0] OP_SHR     = 6'b001001;
   localparam logic [5:0] OP_SAR     = 6'b001010;
   localparam logic [5:0] OP_MUL     = 6'b110010;
   localparam logic [5:0] OP_BAD     = 6'b111111;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] a, b;
   logic [5:0] opcode;
   logic       in_valid, in_ready;
   logic [7:0] c, c_hi;
   logic [3:0] flags;
   logic       illegal, out_valid, out_ready;

   int checks = 0;
   int errors = 0;

   alu_hs #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .opcode(opcode),
      .in_valid(in_valid), .in_ready(in_ready), .c(c), .c_hi(c_hi),
      .flags(flags), .illegal(illegal), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic drive(input logic [5:0] op, input logic [7:0] aa, input logic [7:0] bb);
      opcode   = op;
      a        = aa;
      b        = bb;
      in_valid = 1'b1;
   endtask

   task automatic check_result(input string tag, input logic [7:0] ec, input logic [7:0] ehi,
                               input logic [3:0] ef, input logic eill);
      check({tag, " out_valid"}, out_valid, 1);
      check({tag, " c"}, c, ec);
      check({tag, " c_hi"}, c_hi, ehi);
      check({tag, " flags"}, flags, ef);
      check({tag, " illegal"}, illegal, eill);
   endtask

   // Called right after the accepting edge; returns with the result visible.
   task automatic wait_mul(input string tag);
      int n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         check({tag, " in_ready busy"}, in_ready, 0);
         cyc();
         n++;
      end
      check({tag, " latency"}, n, 9);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; opcode = OP_ZERO;
      repeat (2) @(posedge clk);
      cyc();
      check("rst in_ready", in_ready, 0);
      check("rst out_valid", out_valid, 0);
      check("rst c", c, 0);
      check("rst c_hi", c_hi, 0);
      check("rst flags", flags, 0);
      check("rst illegal", illegal, 0);
      rst_n = 1'b1;
      #1 check("post-rst in_ready", in_ready, 1);

      // Add 0x7F+0x01: signed overflow into negative
      drive(OP_ADD, 8'h7F, 8'h01);
      cyc();
      in_valid = 1'b0;
      check_result("add7f", 8'h80, 8'h00, 4'b1001, 1'b0);
      cyc();
      check("add7f drained", out_valid, 0);

      // Sub 0-1 then Addsub1 0+0-1 back-to-back, then Add FF+01, Sub 80-01
      drive(OP_SUB, 8'h00, 8'h01);
      cyc();
      check_result("sub", 8'hFF, 8'h00, 4'b1010, 1'b0);
      check("sub in_ready", in_ready, 1);
      drive(OP_ADDSUB1, 8'h00, 8'h00);
      cyc();
      check_result("addsub1", 8'hFF, 8'h00, 4'b1010, 1'b0);
      drive(OP_ADD, 8'hFF, 8'h01);
      cyc();
      check_result("add wrap", 8'h00, 8'h00, 4'b0110, 1'b0);
      drive(OP_SUB, 8'h80, 8'h01);
      cyc();
      in_valid = 1'b0;
      check_result("sub ovf", 8'h7F, 8'h00, 4'b0001, 1'b0);
      cyc();
      check("b2b drained", out_valid, 0);

      // Mul 0xFF*0xFF from IDLE, then 3*5 straight from DONE
      drive(OP_MUL, 8'hFF, 8'hFF);
      cyc();
      in_valid = 1'b0;
      wait_mul("mulff");
      check_result("mulff", 8'h01, 8'hFE, 4'b0010, 1'b0);
      drive(OP_MUL, 8'h03, 8'h05);
      cyc();
      in_valid = 1'b0;
      wait_mul("mul35");
      check_result("mul35", 8'h0F, 8'h00, 4'b0000, 1'b0);
      cyc();
      check("mul drained", out_valid, 0);

      // Backpressure: a pending Zero must not displace the stalled Xor result
      out_ready = 1'b0;
      drive(OP_XOR, 8'hF0, 8'hFF);
      cyc();
      drive(OP_ZERO, 8'h00, 8'h00);
      for (int i = 0; i < 5; i++) begin
         check_result("bp hold", 8'h0F, 8'h00, 4'b0000, 1'b0);
         check("bp in_ready", in_ready, 0);
         cyc();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cyc();
      check("bp single transfer", out_valid, 0);

      // Shifts and illegal opcode, back-to-back
      drive(OP_SAR, 8'h90, 8'h0A);
      cyc();
      check_result("sar", 8'hE4, 8'h00, 4'b1000, 1'b0);
      drive(OP_BAD, 8'h12, 8'h34);
      cyc();
      check_result("illegal", 8'hE4, 8'h00, 4'b1000, 1'b1);
      drive(OP_SHL, 8'h81, 8'h01);
      cyc();
      check_result("shl", 8'h02, 8'h00, 4'b0010, 1'b0);
      drive(OP_SHR, 8'h03, 8'h09);
      cyc();
      check_result("shr", 8'h01, 8'h00, 4'b0010, 1'b0);
      drive(OP_SHL, 8'h81, 8'h08);
      cyc();
      in_valid = 1'b0;
      check_result("shl s0", 8'h81, 8'h00, 4'b1000, 1'b0);
      cyc();
      check("shift drained", out_valid, 0);

      // Reset on the 4th busy cycle of a Mul discards it
      drive(OP_MUL, 8'h12, 8'h34);
      cyc();
      in_valid = 1'b0;
      repeat (3) cyc();
      check("pre-rst busy in_ready", in_ready, 0);
      rst_n = 1'b0;
      cyc();
      check("busy rst out_valid", out_valid, 0);
      check("busy rst c", c, 0);
      check("busy rst c_hi", c_hi, 0);
      check("busy rst flags", flags, 0);
      check("busy rst in_ready", in_ready, 0);
      rst_n = 1'b1;
      #1 check("busy rst release in_ready", in_ready, 1);
      for (int i = 0; i < 12; i++) begin
         cyc();
         check("no stale result", out_valid, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
